// File: rtl/trap_edge_walker.sv
// Scanline edge walker: steps the left/right trapezoid edges one scanline at a
// time through the shared adder and hands out one span per scanline.
// Optional macro TRAP_SPAN_SWAP_EN orders span_xl/span_xr so span_xl <= span_xr.
module trap_edge_walker #(
  parameter int XW = 19,
  parameter int YW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [XW-1:0] xl0,
  input  logic [XW-1:0] xr0,
  input  logic [XW-1:0] dxl_mag,
  input  logic [XW-1:0] dxr_mag,
  input  logic          dxl_neg,
  input  logic          dxr_neg,
  input  logic [YW-1:0] y_top,
  input  logic [YW-1:0] y_bot,
  output logic [XW-1:0] add_a,
  output logic [XW-1:0] add_b,
  output logic          add_sub,
  input  logic [XW-1:0] add_sum,
  output logic          span_valid,
  input  logic          span_ready,
  output logic [YW-1:0] span_y,
  output logic [XW-10:0] span_xl,
  output logic [XW-10:0] span_xr,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EMIT   = 3'd1,
    STEP_L = 3'd2,
    STEP_R = 3'd3,
    FIN    = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [XW-1:0]   xl;
  logic [XW-1:0]   xr;
  logic [YW-1:0]   y;

  logic [XW-1:0]   dxl_mag_q;
  logic [XW-1:0]   dxr_mag_q;
  logic            dxl_neg_q;
  logic            dxr_neg_q;
  logic [YW-1:0]   y_bot_q;

  logic            accept;
  logic            swap;
  logic [XW-10:0]  xl_int;
  logic [XW-10:0]  xr_int;

  // Integer part of a Q10.9 edge, fraction truncated.
  function automatic logic [XW-10:0] int_part(input logic [XW-1:0] x);
    return x[XW-1:9];
  endfunction

  assign accept = (state == IDLE) && start;

  // Control state and edge accumulators.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      xl    <= '0;
      xr    <= '0;
      y     <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            xl <= xl0;
            xr <= xr0;
            y  <= y_top;
          end
        end
        STEP_L: xl <= add_sum;
        STEP_R: begin
          xr <= add_sum;
          y  <= y + YW'(1);
        end
        default: ;
      endcase
    end
  end

  // Walk parameters are data only; captured once per walk.
  always_ff @(posedge clk) begin
    if (accept) begin
      dxl_mag_q <= dxl_mag;
      dxr_mag_q <= dxr_mag;
      dxl_neg_q <= dxl_neg;
      dxr_neg_q <= dxr_neg;
      y_bot_q   <= y_bot;
    end
  end

  always_comb begin
    state_nxt  = state;
    add_a      = '0;
    add_b      = '0;
    add_sub    = 1'b0;
    span_valid = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = (y_bot >= y_top) ? EMIT : FIN;
      end
      EMIT: begin
        span_valid = 1'b1;
        if (span_ready) state_nxt = (y == y_bot_q) ? FIN : STEP_L;
      end
      STEP_L: begin
        add_a     = xl;
        add_b     = dxl_mag_q;
        add_sub   = dxl_neg_q;
        state_nxt = STEP_R;
      end
      STEP_R: begin
        add_a     = xr;
        add_b     = dxr_mag_q;
        add_sub   = dxr_neg_q;
        state_nxt = EMIT;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign xl_int = int_part(xl);
  assign xr_int = int_part(xr);

`ifdef TRAP_SPAN_SWAP_EN
  assign swap = (state == EMIT) && (xl_int > xr_int);
`else
  assign swap = 1'b0;
`endif

  assign span_y  = y;
  assign span_xl = swap ? xr_int : xl_int;
  assign span_xr = swap ? xl_int : xr_int;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_trap_edge_walker.sv
// Scoreboard bench for trap_edge_walker: stimulus pushes expected spans, done
// pulses and spot checks; a negedge monitor pops and compares them.
module tb_trap_edge_walker;

  localparam int XW = 19;
  localparam int YW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [XW-1:0] xl0 = '0, xr0 = '0, dxl_mag = '0, dxr_mag = '0;
  logic          dxl_neg = 1'b0, dxr_neg = 1'b0;
  logic [YW-1:0] y_top = '0, y_bot = '0;
  logic [XW-1:0] add_a, add_b, add_sum;
  logic          add_sub;
  logic          span_valid, span_ready, busy, done;
  logic [YW-1:0] span_y;
  logic [9:0]    span_xl, span_xr;

  int cyc = 0;
  int stall_lo = -1, stall_hi = -2;
  int n_tests = 0, n_fail = 0;
  int step_at = -100;
  int scn_req = 0, scn_ack = 0;

  typedef struct {int cyc; int y; int xl; int xr; bit last;} span_t;
  typedef struct {int cyc; bit val;} bchk_t;
  span_t exp_q[$];
  int    done_q[$];
  int    zchk_q[$];
  bchk_t bsy_q[$];

  // Shared adder model.
  assign add_sum    = add_sub ? (add_a - add_b) : (add_a + add_b);
  assign span_ready = !(cyc >= stall_lo && cyc <= stall_hi);

  trap_edge_walker #(.XW(XW), .YW(YW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .xl0(xl0), .xr0(xr0), .dxl_mag(dxl_mag), .dxr_mag(dxr_mag),
    .dxl_neg(dxl_neg), .dxr_neg(dxr_neg), .y_top(y_top), .y_bot(y_bot),
    .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_sum(add_sum),
    .span_valid(span_valid), .span_ready(span_ready), .span_y(span_y),
    .span_xl(span_xl), .span_xr(span_xr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
    end
  endtask

  // Monitor: all comparisons happen here.
  always @(negedge clk) begin
    span_t e;
    if (zchk_q.size() != 0 && zchk_q[0] == cyc) begin
      void'(zchk_q.pop_front());
      chk("zero_valid", span_valid, 0);
      chk("zero_busy", busy, 0);
      chk("zero_done", done, 0);
      chk("zero_add_a", add_a, 0);
      chk("zero_add_b", add_b, 0);
      chk("zero_add_sub", add_sub, 0);
      chk("zero_span_y", span_y, 0);
      chk("zero_span_xl", span_xl, 0);
      chk("zero_span_xr", span_xr, 0);
    end
    if (bsy_q.size() != 0 && bsy_q[0].cyc == cyc) begin
      chk("busy", busy, bsy_q[0].val);
      void'(bsy_q.pop_front());
    end
    if (span_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_span_valid", 1, 0);
      end else begin
        e = exp_q[0];
        chk("span_y", span_y, e.y);
        chk("span_xl", span_xl, e.xl);
        chk("span_xr", span_xr, e.xr);
        if (span_ready) begin
          chk("span_cycle", cyc, e.cyc);
          chk("emit_add_b", add_b, 0);
          chk("emit_add_sub", add_sub, 0);
          void'(exp_q.pop_front());
          if (!e.last) step_at = cyc + 1;
        end
      end
    end
    if (cyc == step_at) begin
      chk("step_l_add_sub", add_sub, dxl_neg);
      chk("step_l_add_b", add_b, dxl_mag);
    end
    if (cyc == step_at + 1) begin
      chk("step_r_add_sub", add_sub, dxr_neg);
      chk("step_r_add_b", add_b, dxr_mag);
    end
    if (done) begin
      if (done_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("done_cycle", cyc, done_q.pop_front());
    end
    if (scn_req != scn_ack) begin
      chk("leftover_spans", exp_q.size(), 0);
      chk("leftover_dones", done_q.size(), 0);
      exp_q.delete();
      done_q.delete();
      scn_ack = scn_req;
    end
  end

  task automatic setup(input int xl_r, input int dxl_r, input bit nl,
                       input int xr_r, input int dxr_r, input bit nr,
                       input int yt, input int yb);
    xl0 = XW'(xl_r); dxl_mag = XW'(dxl_r); dxl_neg = nl;
    xr0 = XW'(xr_r); dxr_mag = XW'(dxr_r); dxr_neg = nr;
    y_top = YW'(yt); y_bot = YW'(yb);
  endtask

  // Raise start for the current cycle; returns that cycle number t.
  task automatic start_hi(output int t);
    @(posedge clk); #1;
    start = 1'b1;
    t = cyc;
  endtask

  task automatic start_lo();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push4(input int t, input int c1, input int c2, input int c3,
                       input int c4, input int y0, input int xl[4], input int xr[4]);
    int cs[4];
    cs = '{c1, c2, c3, c4};
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{t + cs[i], y0 + i, xl[i], xr[i], (i == 3)});
  endtask

  task automatic finish_scn();
    for (int i = 0; i < 300 && (exp_q.size() != 0 || done_q.size() != 0); i++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    scn_req++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    int vx_l[4], vx_r[4];

    // Reset state.
    zchk_q.push_back(2);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Vertical edges.
    setup(10 << 9, 0, 0, 50 << 9, 0, 0, 5, 8);
    start_hi(t);
    vx_l = '{10, 10, 10, 10}; vx_r = '{50, 50, 50, 50};
    push4(t, 1, 4, 7, 10, 5, vx_l, vx_r);
    done_q.push_back(t + 11);
    bsy_q.push_back('{t + 1, 1'b1});
    bsy_q.push_back('{t + 12, 1'b0});
    start_lo();
    finish_scn();

    // Opposing slopes.
    setup(20 << 9, 256, 0, 100 << 9, 768, 1, 0, 3);
    start_hi(t);
    vx_l = '{20, 20, 21, 21}; vx_r = '{100, 98, 97, 95};
    push4(t, 1, 4, 7, 10, 0, vx_l, vx_r);
    done_q.push_back(t + 11);
    start_lo();
    finish_scn();

    // Empty range.
    setup(10 << 9, 0, 0, 50 << 9, 0, 0, 9, 3);
    start_hi(t);
    done_q.push_back(t + 1);
    bsy_q.push_back('{t + 1, 1'b1});
    bsy_q.push_back('{t + 2, 1'b0});
    start_lo();
    finish_scn();

    // Backpressure on the second span.
    setup(10 << 9, 0, 0, 50 << 9, 0, 0, 5, 8);
    start_hi(t);
    stall_lo = t + 4; stall_hi = t + 5;
    vx_l = '{10, 10, 10, 10}; vx_r = '{50, 50, 50, 50};
    push4(t, 1, 6, 9, 12, 5, vx_l, vx_r);
    done_q.push_back(t + 13);
    start_lo();
    finish_scn();
    stall_lo = -1; stall_hi = -2;

    // Reset during STEP_L of the second scanline, then re-walk.
    setup(10 << 9, 0, 0, 50 << 9, 0, 0, 5, 8);
    start_hi(t);
    exp_q.push_back('{t + 1, 5, 10, 50, 1'b0});
    exp_q.push_back('{t + 4, 6, 10, 50, 1'b0});
    zchk_q.push_back(t + 6);
    start_lo();
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    start_hi(t);
    vx_l = '{10, 10, 10, 10}; vx_r = '{50, 50, 50, 50};
    push4(t, 1, 4, 7, 10, 5, vx_l, vx_r);
    done_q.push_back(t + 11);
    start_lo();
    finish_scn();

    // Crossing edges.
    setup(40 << 9, 4 << 9, 0, 50 << 9, 4 << 9, 1, 0, 3);
    start_hi(t);
`ifdef TRAP_SPAN_SWAP_EN
    vx_l = '{40, 44, 42, 38}; vx_r = '{50, 46, 48, 52};
`else
    vx_l = '{40, 44, 48, 52}; vx_r = '{50, 46, 42, 38};
`endif
    push4(t, 1, 4, 7, 10, 0, vx_l, vx_r);
    done_q.push_back(t + 11);
    start_lo();
    finish_scn();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
